// File: rtl/uart_rx_frame_decoder_if.sv
// Receive word handshake between the UART frame decoder and its consumer.
// The decoder drives the word and error flags; the consumer drives data_ready.
interface uart_rx_frame_decoder_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 data_ready;
   logic                 parity_error;
   logic                 framing_error;
   logic                 overrun_error;

   modport master (
      output data_out,
      output data_valid,
      input  data_ready,
      output parity_error,
      output framing_error,
      output overrun_error
   );

   modport slave (
      input  data_out,
      input  data_valid,
      output data_ready,
      input  parity_error,
      input  framing_error,
      input  overrun_error
   );
endinterface

// File: rtl/uart_rx_frame_decoder.sv
// UART receive frame decoder: 16x oversampled start/data/parity/stop
// decoding, presenting each byte on a valid/ready handshake.
module uart_rx_frame_decoder #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic clk_in,
   input  logic reset,
   input  logic baud_clk,
   input  logic rx,
   output logic busy,
   uart_rx_frame_decoder_if.master rx_if
);
   localparam int OSW = $clog2(OVERSAMPLE);
   localparam int BCW = $clog2(DATA_BITS + 1);

   localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);
   localparam logic           P_ODD   = (PARITY_ODD != 0);
   localparam logic           P_EN    = (PARITY_EN != 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]           state;
   logic                 rx_m;
   logic                 rx_s;
   logic                 baud_clk_d;
   logic                 tick;
   logic [OSW-1:0]       os_cnt;
   logic [BCW-1:0]       bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 perr_q;
   logic                 ferr_q;
   logic                 ovr_q;

   assign tick = baud_clk & ~baud_clk_d;
   assign busy = (state != S_IDLE);

   assign rx_if.data_out      = data_q;
   assign rx_if.data_valid    = valid_q;
   assign rx_if.parity_error  = perr_q;
   assign rx_if.framing_error = ferr_q;
   assign rx_if.overrun_error = ovr_q;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state      <= S_IDLE;
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         baud_clk_d <= 1'b0;
         os_cnt     <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bad    <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         rx_m       <= rx;
         rx_s       <= rx_m;
         baud_clk_d <= baud_clk;
         ovr_q      <= 1'b0;
         if (valid_q && rx_if.data_ready)
            valid_q <= 1'b0;
         if (tick) begin
            case (state)
               S_IDLE: begin
                  if (!rx_s) begin
                     os_cnt <= '0;
                     state  <= S_START;
                  end
               end
               S_START: begin
                  if (os_cnt == OS_HALF) begin
                     if (rx_s) begin
                        state <= S_IDLE;
                     end else begin
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                        state   <= S_DATA;
                     end
                  end else begin
                     os_cnt <= os_cnt + 1'b1;
                  end
               end
               S_DATA: begin
                  if (os_cnt == OS_LAST) begin
                     shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                     os_cnt  <= '0;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == BC_LAST)
                        state <= P_EN ? S_PARITY : S_STOP;
                  end else begin
                     os_cnt <= os_cnt + 1'b1;
                  end
               end
               S_PARITY: begin
                  if (os_cnt == OS_LAST) begin
                     par_bad <= ((^shreg) ^ rx_s) != P_ODD;
                     os_cnt  <= '0;
                     state   <= S_STOP;
                  end else begin
                     os_cnt <= os_cnt + 1'b1;
                  end
               end
               S_STOP: begin
                  if (os_cnt == OS_LAST) begin
                     // Load and accept in the same cycle: new word wins, no overrun.
                     os_cnt  <= '0;
                     state   <= S_IDLE;
                     data_q  <= shreg;
                     perr_q  <= par_bad;
                     ferr_q  <= ~rx_s;
                     valid_q <= 1'b1;
                     ovr_q   <= valid_q & ~rx_if.data_ready;
                  end else begin
                     os_cnt <= os_cnt + 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Directed bench: an 8N1 decoder and an 8E1 decoder share clocks,
// baud_clk ticks every second clk_in cycle (one bit = 32 cycles).
module tb_uart_rx_frame_decoder;
   logic clk_in   = 1'b0;
   logic reset    = 1'b1;
   logic baud_clk = 1'b0;
   logic rx0      = 1'b1;
   logic rx1      = 1'b1;
   logic busy0;
   logic busy1;

   int n_checks = 0;
   int n_fail   = 0;
   int ov_cnt   = 0;
   int vrise0   = 0;
   logic v0_d   = 1'b0;

   uart_rx_frame_decoder_if #(.DATA_BITS(8)) if0 ();
   uart_rx_frame_decoder_if #(.DATA_BITS(8)) if1 ();

   uart_rx_frame_decoder #(
      .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)
   ) u_dut0 (
      .clk_in(clk_in), .reset(reset), .baud_clk(baud_clk),
      .rx(rx0), .busy(busy0), .rx_if(if0.master)
   );

   uart_rx_frame_decoder #(
      .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)
   ) u_dut1 (
      .clk_in(clk_in), .reset(reset), .baud_clk(baud_clk),
      .rx(rx1), .busy(busy1), .rx_if(if1.master)
   );

   always #5 clk_in = ~clk_in;

   initial forever begin
      @(negedge clk_in);
      baud_clk = ~baud_clk;
   end

   always @(negedge clk_in) begin
      if (if0.overrun_error) ov_cnt <= ov_cnt + 1;
      if (if0.data_valid && !v0_d) vrise0 <= vrise0 + 1;
      v0_d <= if0.data_valid;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx1 = v;
      else     rx0 = v;
   endtask

   task automatic bit_wait();
      repeat (32) @(negedge clk_in);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d,
                             input bit par_en, input logic par,
                             input bit stop_ok);
      set_rx(sel, 1'b0);
      bit_wait();
      for (int i = 0; i < 8; i++) begin
         set_rx(sel, d[i]);
         bit_wait();
      end
      if (par_en) begin
         set_rx(sel, par);
         bit_wait();
      end
      if (stop_ok) begin
         set_rx(sel, 1'b1);
         bit_wait();
      end else begin
         set_rx(sel, 1'b0);
         repeat (24) @(negedge clk_in);
         set_rx(sel, 1'b1);
         repeat (8) @(negedge clk_in);
      end
      repeat (64) @(negedge clk_in);
   endtask

   task automatic wait_valid(input bit sel, output bit got,
                             output logic [7:0] d, output logic pe,
                             output logic fe, output logic bsy,
                             output logic vnext);
      logic v;
      got = 1'b0; d = '0; pe = 1'b0; fe = 1'b0; bsy = 1'b1; vnext = 1'b1;
      for (int i = 0; i < 600 && !got; i++) begin
         @(negedge clk_in);
         v = sel ? if1.data_valid : if0.data_valid;
         if (v) begin
            got = 1'b1;
            d   = sel ? if1.data_out : if0.data_out;
            pe  = sel ? if1.parity_error : if0.parity_error;
            fe  = sel ? if1.framing_error : if0.framing_error;
            bsy = sel ? busy1 : busy0;
         end
      end
      if (got) begin
         @(negedge clk_in);
         vnext = sel ? if1.data_valid : if0.data_valid;
      end
   endtask

   bit         got;
   logic [7:0] d;
   logic       pe, fe, bsy, vnext;
   int         base;

   initial begin
      if0.data_ready = 1'b1;
      if1.data_ready = 1'b1;
      repeat (5) @(negedge clk_in);
      reset = 1'b0;
      repeat (3) @(negedge clk_in);

      check_eq("rst_data",  if0.data_out, 8'h00);
      check_eq("rst_valid", if0.data_valid, 1'b0);
      check_eq("rst_flags", {if0.parity_error, if0.framing_error,
                             if0.overrun_error}, 3'b000);
      check_eq("rst_busy",  busy0, 1'b0);

      fork
         send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
         wait_valid(1'b0, got, d, pe, fe, bsy, vnext);
      join
      check_eq("a5_got",   got, 1'b1);
      check_eq("a5_data",  d, 8'hA5);
      check_eq("a5_flags", {pe, fe}, 2'b00);
      check_eq("a5_busy_at_valid", bsy, 1'b0);
      check_eq("a5_valid_1cyc", vnext, 1'b0);
      check_eq("a5_busy_after", busy0, 1'b0);

      fork
         send_frame(1'b1, 8'h37, 1'b1, 1'b1, 1'b1);
         wait_valid(1'b1, got, d, pe, fe, bsy, vnext);
      join
      check_eq("par_ok_got",  got, 1'b1);
      check_eq("par_ok_data", d, 8'h37);
      check_eq("par_ok_pe",   pe, 1'b0);

      fork
         send_frame(1'b1, 8'h37, 1'b1, 1'b0, 1'b1);
         wait_valid(1'b1, got, d, pe, fe, bsy, vnext);
      join
      check_eq("par_bad_got",  got, 1'b1);
      check_eq("par_bad_data", d, 8'h37);
      check_eq("par_bad_pe",   pe, 1'b1);
      check_eq("par_bad_fe",   fe, 1'b0);

      fork
         send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
         wait_valid(1'b0, got, d, pe, fe, bsy, vnext);
      join
      check_eq("frm_got",  got, 1'b1);
      check_eq("frm_data", d, 8'h5A);
      check_eq("frm_fe",   fe, 1'b1);

      fork
         send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
         wait_valid(1'b0, got, d, pe, fe, bsy, vnext);
      join
      check_eq("frm_next_got",   got, 1'b1);
      check_eq("frm_next_data",  d, 8'h11);
      check_eq("frm_next_flags", {pe, fe}, 2'b00);

      base = vrise0;
      rx0 = 1'b0;
      repeat (8) @(negedge clk_in);
      check_eq("glitch_busy_hi", busy0, 1'b1);
      rx0 = 1'b1;
      repeat (40) @(negedge clk_in);
      check_eq("glitch_busy_lo", busy0, 1'b0);
      repeat (300) @(negedge clk_in);
      check_eq("glitch_no_valid", vrise0 - base, 0);

      if0.data_ready = 1'b0;
      base = ov_cnt;
      fork
         send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
         wait_valid(1'b0, got, d, pe, fe, bsy, vnext);
      join
      check_eq("ovr_first_data", d, 8'h01);
      check_eq("ovr_first_hold", vnext, 1'b1);
      send_frame(1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
      check_eq("ovr_pulses", ov_cnt - base, 1);
      check_eq("ovr_data",   if0.data_out, 8'h02);
      check_eq("ovr_valid",  if0.data_valid, 1'b1);
      if0.data_ready = 1'b1;
      @(negedge clk_in);
      check_eq("ovr_accept", if0.data_valid, 1'b0);

      base = vrise0;
      fork
         send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
         begin
            repeat (144) @(negedge clk_in);
            check_eq("rst_mid_busy_pre", busy0, 1'b1);
            reset = 1'b1;
            @(negedge clk_in);
            check_eq("rst_mid_busy", busy0, 1'b0);
            reset = 1'b0;
         end
      join
      check_eq("rst_mid_data",  if0.data_out, 8'h00);
      check_eq("rst_mid_valid", if0.data_valid, 1'b0);
      check_eq("rst_mid_flags", {if0.parity_error, if0.framing_error}, 2'b00);
      check_eq("rst_mid_no_out", vrise0 - base, 0);

      fork
         send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
         wait_valid(1'b0, got, d, pe, fe, bsy, vnext);
      join
      check_eq("post_rst_got",  got, 1'b1);
      check_eq("post_rst_data", d, 8'h3C);
      check_eq("post_rst_flags", {pe, fe}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
